// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART Tx unit among NUM_REQ byte clients.
// Ports: clock/rst (sync, active-high); req/req_data/cfg_* from clients; tx_active/tx_done
//   from Tx unit; send/data_in/parity_type/baud_rate/stop_bits/data_length to Tx unit;
//   grant/ack/err one-hot per client; busy high whenever not IDLE.
module uart_tx_sched #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 300000,
  parameter int GUARD_CYCLES   = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [1:0]           cfg_parity,
  input  logic [1:0]           cfg_baud,
  input  logic                 cfg_stop,
  input  logic                 cfg_len,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 send,
  output logic [7:0]           data_in,
  output logic [1:0]           parity_type,
  output logic [1:0]           baud_rate,
  output logic                 stop_bits,
  output logic                 data_length,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_FIN,
    S_GUARD
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [PW-1:0]      rr_ptr;
  logic [TW-1:0]      timer;
  logic [GW-1:0]      guard_cnt;
  logic [NUM_REQ-1:0] grant_q;
  logic [7:0]         data_q;
  logic [1:0]         parity_q;
  logic [1:0]         baud_q;
  logic               stop_q;
  logic               len_q;

  logic               pick_vld;
  logic [PW-1:0]      pick_idx;
  logic [7:0]         pick_byte;
  int                 cand;
  logic               tmo;

  // Search starts one past the last winner so every client gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && req[PW'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == pick_idx) pick_byte = req_data[8*i +: 8];
    end
  end

  assign tmo = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    send     = 1'b0;
    ack      = '0;
    err      = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_vld) state_nx = S_SEND;
      end
      S_SEND: begin
        if (tmo) begin
          err      = grant_q;
          state_nx = S_GUARD;
        end else begin
          send = 1'b1;
          if (tx_active) state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completed frame wins over a timeout landing on the same cycle.
        if (tx_done && !tx_active) begin
          state_nx = S_FIN;
        end else if (tmo) begin
          err      = grant_q;
          state_nx = S_GUARD;
        end
      end
      S_FIN: begin
        ack      = grant_q;
        state_nx = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= PW'(NUM_REQ - 1);
      timer     <= '0;
      guard_cnt <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      parity_q  <= '0;
      baud_q    <= '0;
      stop_q    <= 1'b0;
      len_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && pick_vld) begin
        rr_ptr   <= pick_idx;
        grant_q  <= NUM_REQ'(1) << pick_idx;
        data_q   <= pick_byte;
        parity_q <= cfg_parity;
        baud_q   <= cfg_baud;
        stop_q   <= cfg_stop;
        len_q    <= cfg_len;
        timer    <= '0;
      end
      if (state == S_SEND || state == S_WAIT) timer <= timer + 1'b1;
      if (state != S_GUARD && state_nx == S_GUARD) grant_q <= '0;
      if (state == S_GUARD) guard_cnt <= guard_cnt + 1'b1;
      else                  guard_cnt <= '0;
    end
  end

  assign grant       = grant_q;
  assign data_in     = data_q;
  assign parity_type = parity_q;
  assign baud_rate   = baud_q;
  assign stop_bits   = stop_q;
  assign data_length = len_q;
  assign busy        = (state != S_IDLE);

endmodule
